fixed_point_add_sub: RTL and testbench
======================================

Name: fixed_point_add_sub

Overview:
- Sequential signed fixed-point adder/subtractor with a start/done handshake.
- Operands are two's-complement; the block is format-agnostic (same Q format for both inputs and the output).
- Used as a shared arithmetic unit by DSP filter datapaths; it produces an optionally saturated result with an overflow flag.
- One operation is in flight at a time; the result appears a fixed 2 cycles after an accepted start.

Parameters:
- DATA_WIDTH, 8: width of operands and result, in bits.
- SATURATE, 1: 1 = clamp to max/min on overflow; 0 = wrap (low DATA_WIDTH bits).

Ports:
- i_clk  in  1  rising-edge clock
- i_rst  in  1  reset: asynchronous, active-high
- i_start  in  1  request a new operation (sampled at the clock edge)
- i_sub  in  1  0 = A+B, 1 = A-B; captured with i_start
- i_operandA  in  DATA_WIDTH  signed operand A
- i_operandB  in  DATA_WIDTH  signed operand B
- o_data  out  DATA_WIDTH  signed result
- o_overflow  out  1  result exceeded the signed range; qualifies o_data
- o_valid  out  1  o_data/o_overflow hold a completed result
- o_done  out  1  one-cycle pulse when a result completes
- o_busy  out  1  operation in progress; starts are ignored while high

Behaviour:
- Reset (async assert, i_rst=1): all outputs 0, FSM=IDLE, internal operand/sub/stage registers 0. Reset mid-operation aborts it; no done pulse follows.
- FSM states and transitions:
  - IDLE: on edge with i_start=1 -> capture A, B and sub; o_busy<=1; o_valid<=0; go to CALC.
  - CALC: compute the (DATA_WIDTH+1)-bit sign-extended sum A+B or difference A-B into a stage register; go to DONE.
  - DONE: register o_data and o_overflow; o_valid<=1; o_done<=1; o_busy<=0; go to IDLE.
- Latency: start accepted at edge N -> o_busy high after N; o_done/o_valid high after N+2; o_busy low after N+2.
- o_done is high for exactly one cycle; it clears on the next edge.
- o_valid stays high, and o_data/o_overflow hold, until the next accepted start (which clears o_valid) or reset.
- A start issued in the same cycle o_done is high is accepted (the FSM is back in IDLE).
- i_start while o_busy=1 is ignored. Inputs are sampled only on the accepting edge; later changes to the operands or i_sub do not affect the result.
- Overflow rule: overflow = (extended result bit DATA_WIDTH) != (bit DATA_WIDTH-1).
  - Equivalently, add: sign(A)==sign(B) and sign(result)!=sign(A).
  - Sub: sign(A)!=sign(B) and sign(result)!=sign(A).
- On overflow with SATURATE=1: o_data = max positive (0x7F) if A is non-negative, else min negative (0x80).
- On overflow with SATURATE=0: o_data = low DATA_WIDTH bits of the result.
- Without overflow: o_data = low DATA_WIDTH bits of the result, o_overflow=0.
- Edge case: A = min negative with i_sub=1 and B = min negative gives 0 with no overflow.

Test Plan:
- Reset, then assert i_start=1, i_sub=0, A=0x80, B=0x80 for one cycle; drop i_start and operands to 0.
  -> o_busy=1 for 2 cycles; o_done one-cycle pulse at N+2; o_overflow=1; o_data=0x80 (saturated); o_valid stays 1 with the operands at 0.
- A=0x7F, B=0x01, add -> o_overflow=1, o_data=0x7F; with SATURATE=0 -> o_data=0x80.
- A=0x10, B=0x30, sub -> o_data=0xE0 (-32), o_overflow=0.
- A=0x80, B=0x01, sub -> overflow, o_data=0x80. A=0x80, B=0x80, sub -> o_data=0x00, no overflow.
- Assert a second i_start while busy, with different operands -> ignored; the result matches the first operation. A start in the o_done cycle is accepted.
- Assert i_rst during CALC -> all outputs 0 immediately (asynchronously); no o_done; the next start works normally.

Source files
------------

// File: rtl/fixed_point_add_sub.sv
// Sequential signed fixed-point adder/subtractor with a start/done handshake.
// A result appears two cycles after an accepted start, optionally saturated on overflow.
module fixed_point_add_sub #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_sub,
  input  logic [DATA_WIDTH-1:0] i_operandA,
  input  logic [DATA_WIDTH-1:0] i_operandB,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_overflow,
  output logic                  o_valid,
  output logic                  o_done,
  output logic                  o_busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [DATA_WIDTH-1:0] MaxPos = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                state_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  sub_q;
  logic [DATA_WIDTH:0]   sum_q;

  logic [DATA_WIDTH:0]   a_ext;
  logic [DATA_WIDTH:0]   b_ext;
  logic [DATA_WIDTH:0]   sum_d;
  logic                  ovf;
  logic [DATA_WIDTH-1:0] res;

  always_comb begin
    a_ext = {a_q[DATA_WIDTH-1], a_q};
    b_ext = {b_q[DATA_WIDTH-1], b_q};
    sum_d = sub_q ? (a_ext - b_ext) : (a_ext + b_ext);
    // The extra sign bit disagrees with the top result bit only when the range was exceeded.
    ovf   = sum_q[DATA_WIDTH] ^ sum_q[DATA_WIDTH-1];
    res   = sum_q[DATA_WIDTH-1:0];
    if (ovf && SATURATE) begin
      res = a_q[DATA_WIDTH-1] ? MinNeg : MaxPos;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      sum_q      <= '0;
      o_data     <= '0;
      o_overflow <= 1'b0;
      o_valid    <= 1'b0;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          o_done <= 1'b0;
          if (i_start) begin
            a_q     <= i_operandA;
            b_q     <= i_operandB;
            sub_q   <= i_sub;
            o_busy  <= 1'b1;
            o_valid <= 1'b0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          sum_q   <= sum_d;
          state_q <= StDone;
        end
        StDone: begin
          o_data     <= res;
          o_overflow <= ovf;
          o_valid    <= 1'b1;
          o_done     <= 1'b1;
          o_busy     <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_add_sub.sv
// Randomised and directed bench for fixed_point_add_sub; a saturating and a wrapping
// instance share the same stimulus and are checked against an integer reference model.
module tb_fixed_point_add_sub;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;

  logic [W-1:0] s_data, w_data;
  logic         s_ovf, w_ovf, s_valid, w_valid, s_done, w_done, s_busy, w_busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fixed_point_add_sub #(.DATA_WIDTH(W), .SATURATE(1'b1)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub),
    .i_operandA(op_a), .i_operandB(op_b),
    .o_data(s_data), .o_overflow(s_ovf), .o_valid(s_valid), .o_done(s_done), .o_busy(s_busy)
  );

  fixed_point_add_sub #(.DATA_WIDTH(W), .SATURATE(1'b0)) dut_wrap (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub),
    .i_operandA(op_a), .i_operandB(op_b),
    .o_data(w_data), .o_overflow(w_ovf), .o_valid(w_valid), .o_done(w_done), .o_busy(w_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, then range test and clamp/wrap.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] e_sat, output logic [W-1:0] e_wrap,
                       output logic e_ovf);
    int ia, ib, r, lo, hi;
    ia = $signed(a);
    ib = $signed(b);
    r  = s ? ia - ib : ia + ib;
    hi = (1 << (W - 1)) - 1;
    lo = -(1 << (W - 1));
    e_ovf  = (r > hi) || (r < lo);
    e_wrap = r[W-1:0];
    if (r > hi)      e_sat = hi[W-1:0];
    else if (r < lo) e_sat = lo[W-1:0];
    else             e_sat = r[W-1:0];
  endtask

  task automatic check_idle_result(input string tag, input logic [W-1:0] e_sat,
                                   input logic [W-1:0] e_wrap, input logic e_ovf);
    check({tag, "_sdata"}, 32'(s_data), 32'(e_sat));
    check({tag, "_wdata"}, 32'(w_data), 32'(e_wrap));
    check({tag, "_sovf"}, 32'(s_ovf), 32'(e_ovf));
    check({tag, "_wovf"}, 32'(w_ovf), 32'(e_ovf));
    check({tag, "_valid"}, 32'({s_valid, w_valid}), 32'h3);
  endtask

  // Called at a negedge with the DUTs idle (or in their done cycle); returns at the
  // negedge of the done cycle. Inputs are scrambled after the accepting edge.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input bit poke_busy);
    logic [W-1:0] e_sat, e_wrap;
    logic         e_ovf;
    model(a, b, s, e_sat, e_wrap, e_ovf);
    start = 1'b1; op_a = a; op_b = b; sub = s;
    @(posedge clk);
    @(negedge clk);
    start = poke_busy;
    op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
    check({tag, "_busy1"}, 32'({s_busy, w_busy}), 32'h3);
    check({tag, "_vclr"}, 32'({s_valid, w_valid}), 32'h0);
    check({tag, "_nodone1"}, 32'({s_done, w_done}), 32'h0);
    @(posedge clk);
    @(negedge clk);
    op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
    check({tag, "_busy2"}, 32'({s_busy, w_busy}), 32'h3);
    check({tag, "_nodone2"}, 32'({s_done, w_done}), 32'h0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done"}, 32'({s_done, w_done}), 32'h3);
    check({tag, "_nbusy"}, 32'({s_busy, w_busy}), 32'h0);
    check_idle_result(tag, e_sat, e_wrap, e_ovf);
  endtask

  logic [W-1:0] h_sat, h_wrap;
  logic         h_ovf;

  initial begin
    rst = 1'b1;
    #12;
    check("rst_out", 32'({s_data, s_ovf, s_valid, s_done, s_busy}), 32'h0);
    check("rst_outw", 32'({w_data, w_ovf, w_valid, w_done, w_busy}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("minmin_add", 8'h80, 8'h80, 1'b0, 1'b0);
    check("minmin_sat", 32'(s_data), 32'h80);
    op_a = '0; op_b = '0;
    @(negedge clk);
    check("hold_nodone", 32'({s_done, w_done}), 32'h0);
    check_idle_result("hold", 8'h80, 8'h00, 1'b1);

    run_op("maxp1", 8'h7F, 8'h01, 1'b0, 1'b0);
    check("maxp1_sat", 32'(s_data), 32'h7F);
    check("maxp1_wrap", 32'(w_data), 32'h80);
    run_op("sub_neg", 8'h10, 8'h30, 1'b0 | 1'b1, 1'b0);
    check("sub_neg_val", 32'(s_data), 32'hE0);
    run_op("min_sub1", 8'h80, 8'h01, 1'b1, 1'b0);
    run_op("min_submin", 8'h80, 8'h80, 1'b1, 1'b0);
    check("min_submin_z", 32'({s_data, s_ovf}), 32'h0);

    // Starts held high through CALC and DONE must be ignored.
    run_op("busy_ign", 8'h25, 8'h13, 1'b0, 1'b1);
    @(negedge clk);
    check("busy_ign_idle", 32'({s_busy, w_busy, s_done}), 32'h0);
    model(8'h25, 8'h13, 1'b0, h_sat, h_wrap, h_ovf);
    check_idle_result("busy_ign_hold", h_sat, h_wrap, h_ovf);

    // Back-to-back: the second start lands in the done cycle of the first.
    run_op("b2b_1", 8'h40, 8'h40, 1'b0, 1'b0);
    run_op("b2b_2", 8'hC0, 8'h41, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_doneclr", 32'({s_done, w_done}), 32'h0);

    // Asynchronous reset during CALC aborts the operation.
    start = 1'b1; op_a = 8'h7F; op_b = 8'h7F; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out", 32'({s_data, s_ovf, s_valid, s_done, s_busy}), 32'h0);
    check("arst_outw", 32'({w_data, w_ovf, w_valid, w_done, w_busy}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_nodone", 32'({s_done, s_valid, s_busy, w_done, w_valid, w_busy}), 32'h0);
    end
    run_op("post_rst", 8'h05, 8'h0A, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
